bp_fe_bht_2lvl: RTL and testbench

Parametrised two-level branch direction predictor for the front end: a table of N-bit saturating counters indexed either directly (bimodal) or by PC index XOR global history (gshare). Sits beside the BTB in the fetch stage; predictions are registered, one cycle after the request. Resolved branches train it through a single update port. A built-in clear sequencer initialises the table after reset, so the table needs no wide reset fan-out.

---
 rtl/bp_fe_bht_2lvl.sv | 131 +++++++++++++
 tb/tb_bp_fe_bht_2lvl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_fe_bht_2lvl.sv
// Two-level branch direction predictor: a table of saturating counters indexed bimodally or by gshare.
// A clear sequencer fills the table after reset, and the prediction read is registered.
module bp_fe_bht_2lvl #(
    parameter int unsigned bht_idx_width_p = 9,
    parameter int unsigned ghist_width_p   = 8,
    parameter int unsigned ctr_width_p     = 2,
    parameter bit          hash_mode_p     = 1'b1
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    output logic                       init_done_o,
    input  logic                       r_v_i,
    input  logic [bht_idx_width_p-1:0] r_idx_i,
    output logic                       predict_v_o,
    output logic                       predict_o,
    output logic [bht_idx_width_p-1:0] predict_idx_o,
    input  logic                       w_v_i,
    input  logic [bht_idx_width_p-1:0] w_idx_i,
    input  logic                       w_taken_i,
    output logic [ghist_width_p-1:0]   ghist_o
);

    localparam int unsigned Entries = 1 << bht_idx_width_p;

    localparam logic [1:0] StReset = 2'd0;
    localparam logic [1:0] StClear = 2'd1;
    localparam logic [1:0] StRun   = 2'd2;

    localparam logic [ctr_width_p-1:0] CtrOne  = ctr_width_p'(1);
    localparam logic [ctr_width_p-1:0] CtrMax  = '1;
    localparam logic [ctr_width_p-1:0] CtrInit = ctr_width_p'((32'd1 << (ctr_width_p - 1)) - 32'd1);
    localparam logic [bht_idx_width_p-1:0] IdxLast = '1;

    logic [1:0]                 state_q, state_d;
    logic [bht_idx_width_p-1:0] clr_ptr_q;
    logic [ctr_width_p-1:0]     table_q [Entries];
    logic [ghist_width_p-1:0]   ghist_q, ghist_shift;
    logic                       predict_v_q, predict_q;
    logic [bht_idx_width_p-1:0] predict_idx_q;

    logic                       run;
    logic [bht_idx_width_p-1:0] ghist_ext, r_hidx;
    logic [ctr_width_p-1:0]     w_ctr, w_ctr_next;
    logic                       wr_en;
    logic [bht_idx_width_p-1:0] wr_idx;
    logic [ctr_width_p-1:0]     wr_val;

    assign run = (state_q == StRun);

    always_comb begin
        ghist_ext = '0;
        ghist_ext[ghist_width_p-1:0] = ghist_q;
        r_hidx = hash_mode_p ? (r_idx_i ^ ghist_ext) : r_idx_i;
    end

    if (ghist_width_p == 1) begin : g_ghist_one
        assign ghist_shift = w_taken_i;
    end else begin : g_ghist_many
        assign ghist_shift = {ghist_q[ghist_width_p-2:0], w_taken_i};
    end

    // StReset and StClear both write the clear pointer; StReset only marks the first clear cycle.
    always_comb begin
        state_d = state_q;
        if (!run && clr_ptr_q == IdxLast) begin
            state_d = StRun;
        end else if (state_q == StReset) begin
            state_d = StClear;
        end
    end

    always_comb begin
        w_ctr = table_q[w_idx_i];
        if (w_taken_i) begin
            w_ctr_next = (w_ctr == CtrMax) ? w_ctr : w_ctr + CtrOne;
        end else begin
            w_ctr_next = (w_ctr == '0) ? w_ctr : w_ctr - CtrOne;
        end
        wr_en  = 1'b0;
        wr_idx = w_idx_i;
        wr_val = w_ctr_next;
        if (!reset_i) begin
            if (!run) begin
                wr_en  = 1'b1;
                wr_idx = clr_ptr_q;
                wr_val = CtrInit;
            end else begin
                wr_en = w_v_i;
            end
        end
    end

    // Table has no reset; the clear sequencer initialises it.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            table_q[wr_idx] <= wr_val;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= StReset;
            clr_ptr_q     <= '0;
            ghist_q       <= '0;
            predict_v_q   <= 1'b0;
            predict_q     <= 1'b0;
            predict_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            predict_v_q <= run && r_v_i;
            if (!run) begin
                clr_ptr_q <= clr_ptr_q + 1'b1;
            end
            // Read sees the pre-write counter and the pre-shift history.
            if (run && r_v_i) begin
                predict_q     <= table_q[r_hidx][ctr_width_p-1];
                predict_idx_q <= r_hidx;
            end
            if (run && w_v_i) begin
                ghist_q <= ghist_shift;
            end
        end
    end

    assign init_done_o   = run;
    assign predict_v_o   = predict_v_q;
    assign predict_o     = predict_q;
    assign predict_idx_o = predict_idx_q;
    assign ghist_o       = ghist_q;

endmodule

// File: tb/tb_bp_fe_bht_2lvl.sv
// Bench for bp_fe_bht_2lvl: four parameterisations share one stimulus stream and are checked
// every cycle against a behavioural table model, plus directed literal expectations.
module tb_bp_fe_bht_2lvl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, r_v, w_v, w_taken;
    logic [8:0] r_idx, w_idx;

    logic       idone0, idone1, idone2, idone3;
    logic       pv0, pv1, pv2, pv3;
    logic       po0, po1, po2, po3;
    logic [8:0] pidx0, pidx1, pidx2, pidx3;
    logic [7:0] gh0, gh2, gh3;
    logic [0:0] gh1;

    // d0: defaults (gshare, 2-bit); d1: 1-bit ctr, 1-bit history; d2: 3-bit bimodal; d3: 2-bit bimodal
    bp_fe_bht_2lvl #(.bht_idx_width_p(9), .ghist_width_p(8), .ctr_width_p(2), .hash_mode_p(1'b1)) d0 (
        .clk_i(clk), .reset_i(reset), .init_done_o(idone0), .r_v_i(r_v), .r_idx_i(r_idx),
        .predict_v_o(pv0), .predict_o(po0), .predict_idx_o(pidx0), .w_v_i(w_v), .w_idx_i(w_idx),
        .w_taken_i(w_taken), .ghist_o(gh0));
    bp_fe_bht_2lvl #(.bht_idx_width_p(9), .ghist_width_p(1), .ctr_width_p(1), .hash_mode_p(1'b1)) d1 (
        .clk_i(clk), .reset_i(reset), .init_done_o(idone1), .r_v_i(r_v), .r_idx_i(r_idx),
        .predict_v_o(pv1), .predict_o(po1), .predict_idx_o(pidx1), .w_v_i(w_v), .w_idx_i(w_idx),
        .w_taken_i(w_taken), .ghist_o(gh1));
    bp_fe_bht_2lvl #(.bht_idx_width_p(9), .ghist_width_p(8), .ctr_width_p(3), .hash_mode_p(1'b0)) d2 (
        .clk_i(clk), .reset_i(reset), .init_done_o(idone2), .r_v_i(r_v), .r_idx_i(r_idx),
        .predict_v_o(pv2), .predict_o(po2), .predict_idx_o(pidx2), .w_v_i(w_v), .w_idx_i(w_idx),
        .w_taken_i(w_taken), .ghist_o(gh2));
    bp_fe_bht_2lvl #(.bht_idx_width_p(9), .ghist_width_p(8), .ctr_width_p(2), .hash_mode_p(1'b0)) d3 (
        .clk_i(clk), .reset_i(reset), .init_done_o(idone3), .r_v_i(r_v), .r_idx_i(r_idx),
        .predict_v_o(pv3), .predict_o(po3), .predict_idx_o(pidx3), .w_v_i(w_v), .w_idx_i(w_idx),
        .w_taken_i(w_taken), .ghist_o(gh3));

    logic       idone_a [4];
    logic       pv_a    [4];
    logic       po_a    [4];
    logic [8:0] pidx_a  [4];
    logic [7:0] gh_a    [4];

    always_comb begin
        idone_a[0] = idone0; idone_a[1] = idone1; idone_a[2] = idone2; idone_a[3] = idone3;
        pv_a[0] = pv0; pv_a[1] = pv1; pv_a[2] = pv2; pv_a[3] = pv3;
        po_a[0] = po0; po_a[1] = po1; po_a[2] = po2; po_a[3] = po3;
        pidx_a[0] = pidx0; pidx_a[1] = pidx1; pidx_a[2] = pidx2; pidx_a[3] = pidx3;
        gh_a[0] = gh0; gh_a[1] = {7'b0, gh1}; gh_a[2] = gh2; gh_a[3] = gh3;
    end

    function automatic int cw(int k);
        case (k)
            1:       return 1;
            2:       return 3;
            default: return 2;
        endcase
    endfunction
    function automatic int gw(int k);
        return (k == 1) ? 1 : 8;
    endfunction
    function automatic bit hm(int k);
        return (k <= 1);
    endfunction

    int n_vec = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: table of integers, clear pointer, history as an integer.
    int m_cnt   [4][512];
    bit m_run   [4];
    int m_ptr   [4];
    int m_gh    [4];
    bit m_pv    [4];
    bit m_po    [4];
    int m_pidx  [4];

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            int cmax, h, c;
            cmax = (1 << cw(k)) - 1;
            if (reset) begin
                m_run[k] = 1'b0; m_ptr[k] = 0; m_gh[k] = 0;
                m_pv[k] = 1'b0; m_po[k] = 1'b0; m_pidx[k] = 0;
            end else if (!m_run[k]) begin
                m_cnt[k][m_ptr[k]] = (1 << (cw(k) - 1)) - 1;
                if (m_ptr[k] == 511) m_run[k] = 1'b1;
                m_ptr[k] = (m_ptr[k] + 1) % 512;
                m_pv[k] = 1'b0;
            end else begin
                if (r_v) begin
                    h = hm(k) ? (int'(r_idx) ^ m_gh[k]) : int'(r_idx);
                    m_po[k]   = (m_cnt[k][h] >= (1 << (cw(k) - 1)));
                    m_pidx[k] = h;
                    m_pv[k]   = 1'b1;
                end else begin
                    m_pv[k] = 1'b0;
                end
                if (w_v) begin
                    c = m_cnt[k][w_idx];
                    if (w_taken) c = (c < cmax) ? c + 1 : cmax;
                    else         c = (c > 0) ? c - 1 : 0;
                    m_cnt[k][w_idx] = c;
                    m_gh[k] = ((m_gh[k] << 1) | int'(w_taken)) & ((1 << gw(k)) - 1);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int k = 0; k < 4; k++) begin
                check($sformatf("d%0d init_done", k), 32'(idone_a[k]), 32'(m_run[k]));
                check($sformatf("d%0d predict_v", k), 32'(pv_a[k]), 32'(m_pv[k]));
                check($sformatf("d%0d predict", k), 32'(po_a[k]), 32'(m_po[k]));
                check($sformatf("d%0d predict_idx", k), 32'(pidx_a[k]), 32'(m_pidx[k]));
                check($sformatf("d%0d ghist", k), 32'(gh_a[k]), 32'(m_gh[k]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic read(logic [8:0] idx);
        r_v = 1'b1; r_idx = idx;
        tick();
        r_v = 1'b0;
    endtask

    task automatic update(logic [8:0] idx, logic taken, int n);
        w_v = 1'b1; w_idx = idx; w_taken = taken;
        ticks(n);
        w_v = 1'b0;
    endtask

    task automatic sweep_reads(string tag);
        r_v = 1'b1;
        for (int i = 0; i < 512; i++) begin
            r_idx = 9'(i);
            tick();
            for (int k = 0; k < 4; k++) check($sformatf("%s d%0d idx %0d", tag, k, i), 32'(po_a[k]), 0);
        end
        r_v = 1'b0;
    endtask

    task automatic check_init_edge(string tag);
        for (int k = 0; k < 4; k++) check($sformatf("%s d%0d init@511", tag, k), 32'(idone_a[k]), 0);
        tick();
        for (int k = 0; k < 4; k++) check($sformatf("%s d%0d init@512", tag, k), 32'(idone_a[k]), 1);
    endtask

    initial begin
        reset = 1'b1; r_v = 1'b0; w_v = 1'b0; w_taken = 1'b0; r_idx = '0; w_idx = '0;
        tick();
        cmp_en = 1'b1;
        ticks(2);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rst d%0d predict_v", k), 32'(pv_a[k]), 0);
            check($sformatf("rst d%0d ghist", k), 32'(gh_a[k]), 0);
        end

        // Clear: request at cycle 100 must be dropped; done exactly at cycle 512
        reset = 1'b0;
        ticks(100);
        read(9'd3);
        check("clear r_v dropped", 32'(pv0), 0);
        ticks(410);
        check_init_edge("clear");
        sweep_reads("after clear");

        // gshare: history 101 then hashed index
        update(9'h1F0, 1'b1, 1);
        update(9'h1F0, 1'b0, 1);
        update(9'h1F0, 1'b1, 1);
        check("gshare ghist", 32'(gh0), 32'h05);
        read(9'h0A0);
        check("gshare pidx", 32'(pidx0), 32'h0A5);
        check("gshare pred before", 32'(po0), 0);
        update(9'h0A5, 1'b1, 2);
        // Two more history shifts make ghist 0x17, so 0x0B2 hashes back to 0x0A5.
        check("gshare ghist 2", 32'(gh0), 32'h17);
        read(9'h0B2);
        check("gshare pidx 2", 32'(pidx0), 32'h0A5);
        check("gshare pred after", 32'(po0), 1);

        // Simultaneous read/write of idx 7 (d3 bimodal, counter 01)
        r_v = 1'b1; r_idx = 9'd7; w_v = 1'b1; w_idx = 9'd7; w_taken = 1'b1;
        tick();
        w_v = 1'b0;
        check("simul pre-update", 32'(po3), 0);
        tick();
        r_v = 1'b0;
        check("simul post-update", 32'(po3), 1);

        // Saturation on idx 5 (d3 bimodal 2-bit)
        update(9'd5, 1'b1, 3);
        read(9'd5);
        check("sat taken x3", 32'(po3), 1);
        update(9'd5, 1'b1, 1);
        update(9'd5, 1'b0, 1);
        read(9'd5);
        check("sat hi held", 32'(po3), 1);
        update(9'd5, 1'b0, 3);
        read(9'd5);
        check("sat not-taken x4", 32'(po3), 0);
        update(9'd5, 1'b0, 1);
        update(9'd5, 1'b1, 1);
        read(9'd5);
        check("sat lo held", 32'(po3), 0);
        update(9'd5, 1'b1, 1);
        read(9'd5);
        check("sat climb", 32'(po3), 1);

        // Reset in the middle of a clear
        reset = 1'b1;
        ticks(3);
        reset = 1'b0;
        ticks(200);
        reset = 1'b1;
        tick();
        check("midclear ghist", 32'(gh0), 0);
        check("midclear pidx", 32'(pidx0), 0);
        reset = 1'b0;
        ticks(511);
        check_init_edge("midclear");
        sweep_reads("after midclear");

        // Random traffic, concentrated on a few entries so counters saturate
        for (int i = 0; i < 4000; i++) begin
            r_v     = 1'($urandom_range(0, 1));
            r_idx   = ($urandom_range(0, 3) == 0) ? 9'($urandom) : 9'($urandom_range(0, 15));
            w_v     = 1'($urandom_range(0, 1));
            w_idx   = ($urandom_range(0, 3) == 0) ? 9'($urandom) : 9'($urandom_range(0, 15));
            w_taken = ($urandom_range(0, 3) != 0);
            tick();
        end
        r_v = 1'b0; w_v = 1'b0;
        ticks(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
